sobel_stream: RTL and testbench
===============================

SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 Parameter PIX_W, default 8: pixel width in bits, legal range 4..12.
REQ-002 Parameter IMG_W, default 640: pixels per line, legal range 3..4096.
REQ-003 Parameter THR_EN, default 1: when 1, the binary-threshold output stage is built; when 0, `thr_on` is ignored.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 mode  in  1  kernel select: 0 = Sobel (centre weight 2), 1 = Prewitt (centre weight 1); sampled per accepted pixel.
REQ-007 thr_on  in  1  1 selects threshold output; 0 selects magnitude output.
REQ-008 thr  in  PIX_W  threshold level.
REQ-009 in_valid  in  1  input pixel valid.
REQ-010 in_ready  out  1  block can accept an input pixel.
REQ-011 in_sof  in  1  first pixel of a frame, qualified by in_valid.
REQ-012 in_pix  in  PIX_W  raster-order unsigned pixel.
REQ-013 out_valid  out  1  output pixel valid.
REQ-014 out_ready  in  1  downstream accepts the output pixel.
REQ-015 out_pix  out  PIX_W  edge magnitude or threshold result.
REQ-016 out_eol  out  1  last output pixel of an output line.

Function
REQ-017 A transfer shall occur on any edge with valid && ready high, on either port.
REQ-018 Two line buffers of IMG_W x PIX_W plus a 3x3 window register shall hold rows r-2..r and columns c-2..c.
REQ-019 Column and row counters shall advance on each accepted pixel; column wraps at IMG_W-1 to 0 and increments the row; accepted in_sof forces column 0 / row 0 for that pixel, mid-frame included.
REQ-020 Output shall be produced only for windows with row>=2 and col>=2, giving (IMG_W-2) outputs per line with no border padding.
REQ-021 Gradients: gx = (p2-p0) + k(p5-p3) + (p8-p6) and gy = (p0-p6) + k(p1-p7) + (p2-p8), where k = 2 in Sobel and 1 in Prewitt.
REQ-022 Gradients shall be signed, PIX_W+3 bits wide, and computed without overflow.
REQ-023 Magnitude: sum = |gx| + |gy|, unsigned, PIX_W+4 bits wide; out_pix = min(sum, 2^PIX_W-1).
REQ-024 Threshold (THR_EN=1, thr_on=1): out_pix = all-ones if the saturated sum >= thr, otherwise 0.
REQ-025 The pipeline shall have 3 stages (window capture, gradients, abs/sum/saturate); latency from accepting the completing pixel to out_valid shall be 3 cycles when unstalled.
REQ-026 Stall: the pipeline shall advance when out_ready is high or the output register is empty; in_ready equals that advance condition; no pixel is dropped or duplicated.
REQ-027 out_pix and out_eol shall hold stable while out_valid is high and out_ready is low.
REQ-028 out_eol shall be set on the output derived from column IMG_W-1.
REQ-029 mode, thr_on and thr shall travel with each pixel through the pipeline, so a change affects only pixels accepted after it.
REQ-030 Full throughput of 1 pixel per cycle shall be sustained with out_ready held high.

Reset
REQ-031 On rst: out_valid=0, out_pix=0, out_eol=0, and the counters, stage-valid bits and window registers are cleared.
REQ-032 in_ready shall read 1 during and after reset.
REQ-033 Line-buffer RAM contents are not reset; output gating by row>=2 after reset or sof guarantees stale data never reaches out_pix.
REQ-034 A reset asserted mid-frame shall abandon all in-flight pixels; the next accepted pixel is treated as row 0, col 0.

Structure
REQ-035 A shared package sobel_pkg shall hold the kernel-mode enumeration (SOBEL, PREWITT) and a function giving gradient width from PIX_W.
REQ-036 One sub-module, sobel_linebuf (a single-port IMG_W-deep delay line with read-before-write), shall be instantiated twice.
REQ-037 The arithmetic shall be combinational between pipeline registers; no multipliers (k applied by shift).

Verification
REQ-038 IMG_W=8, PIX_W=8, flat frame of all 100, Sobel -> 6 outputs per row from row 2, all 0, out_eol on every 6th.
REQ-039 Vertical step (cols 0-3 = 0, cols 4-7 = 255), Sobel -> out_pix=255 at the window centred on cols 3 and 4 (sum 1020 saturated), 0 elsewhere.
REQ-040 Same step, Prewitt, PIX_W=10 -> out_pix=765 at the edge windows.
REQ-041 Random frame with out_ready toggled randomly at 50% -> output stream identical to a reference model with out_ready held at 1; pixel count = 36 per 8x8 frame.
REQ-042 thr_on=1, thr=128, ramp image with gx=64 -> all outputs 0; thr=64 -> all 255.
REQ-043 Reset at row 4, then a new frame with in_sof -> first out_valid 3 cycles after row 2, col 2 is accepted; no earlier output.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared kernel-mode type and width helpers for the Sobel/Prewitt stream filter.
package sobel_pkg;

   typedef enum logic {
      SOBEL   = 1'b0,
      PREWITT = 1'b1
   } kernel_mode_e;

   // Signed gradient width: up to 4*(2^pix_w-1) in magnitude plus a sign bit.
   function automatic int grad_width(input int pix_w);
      return pix_w + 3;
   endfunction

   function automatic int sum_width(input int pix_w);
      return pix_w + 4;
   endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// Single-port delay line of DEPTH entries; the old entry is read before it is overwritten.
module sobel_linebuf #(
   parameter int W     = 8,
   parameter int DEPTH = 640
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (en) begin
         ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Contents are deliberately not reset; row gating keeps stale data out of the result.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[ptr_q] <= din;
      end
   end

   assign dout = mem[ptr_q];

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel/Prewitt edge filter: window capture, gradients, then abs/sum/saturate
// with an optional binary threshold, all three stages stalling together on output backpressure.
module sobel_stream
   import sobel_pkg::*;
#(
   parameter int PIX_W  = 8,
   parameter int IMG_W  = 640,
   parameter int THR_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             thr_on,
   input  logic [PIX_W-1:0] thr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pix,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pix,
   output logic             out_eol
);

   localparam int GW = grad_width(PIX_W);
   localparam int SW = sum_width(PIX_W);
   localparam int CW = $clog2(IMG_W);
   localparam logic [SW-1:0] PIX_MAX = SW'((1 << PIX_W) - 1);

   logic advance, accept;
   logic [CW-1:0] col_q, col_d, cur_col;
   logic [1:0]    row_q, row_d, cur_row;
   logic [PIX_W-1:0] row1_pix, row2_pix;

   logic [PIX_W-1:0] win_q [9];
   logic [PIX_W-1:0] win_d [9];
   logic             s1_valid_q, s1_valid_d, s1_eol_q, s1_eol_d, s1_thr_on_q, s1_thr_on_d;
   kernel_mode_e     s1_mode_q, s1_mode_d;
   logic [PIX_W-1:0] s1_thr_q, s1_thr_d;

   logic signed [GW-1:0] ext [9];
   logic signed [GW-1:0] dx, dy, gx, gy, gx_q, gx_d, gy_q, gy_d;
   logic             s2_valid_q, s2_valid_d, s2_eol_q, s2_eol_d, s2_thr_on_q, s2_thr_on_d;
   logic [PIX_W-1:0] s2_thr_q, s2_thr_d;

   logic [GW-1:0]    abs_x, abs_y;
   logic [SW-1:0]    sum;
   logic [PIX_W-1:0] sat, result;
   logic             out_valid_q, out_valid_d, out_eol_q, out_eol_d;
   logic [PIX_W-1:0] out_pix_q, out_pix_d;

   assign advance  = out_ready || !out_valid_q;
   assign in_ready = advance;
   assign accept   = in_valid && advance;

   sobel_linebuf #(.W(PIX_W), .DEPTH(IMG_W)) u_lb_row1 (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .din (in_pix),
      .dout(row1_pix)
   );

   sobel_linebuf #(.W(PIX_W), .DEPTH(IMG_W)) u_lb_row2 (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .din (row1_pix),
      .dout(row2_pix)
   );

   // Row only needs to distinguish 0, 1 and "2 or more", so it saturates at 2.
   always_comb begin
      cur_col = in_sof ? '0 : col_q;
      cur_row = in_sof ? 2'd0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      if (accept) begin
         if (cur_col == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
         end else begin
            col_d = cur_col + CW'(1);
            row_d = cur_row;
         end
      end
   end

   always_comb begin
      win_d       = win_q;
      s1_valid_d  = s1_valid_q;
      s1_eol_d    = s1_eol_q;
      s1_mode_d   = s1_mode_q;
      s1_thr_on_d = s1_thr_on_q;
      s1_thr_d    = s1_thr_q;
      if (advance) begin
         s1_valid_d = accept && (cur_row == 2'd2) && (cur_col >= CW'(2));
      end
      if (accept) begin
         win_d[0]    = win_q[1];
         win_d[1]    = win_q[2];
         win_d[2]    = row2_pix;
         win_d[3]    = win_q[4];
         win_d[4]    = win_q[5];
         win_d[5]    = row1_pix;
         win_d[6]    = win_q[7];
         win_d[7]    = win_q[8];
         win_d[8]    = in_pix;
         s1_eol_d    = (cur_col == CW'(IMG_W - 1));
         s1_mode_d   = kernel_mode_e'(mode);
         s1_thr_on_d = thr_on;
         s1_thr_d    = thr;
      end
   end

   // The centre weight of 2 is a single left shift of the centre difference.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         ext[i] = $signed({3'b000, win_q[i]});
      end
      dx = ext[5] - ext[3];
      dy = ext[1] - ext[7];
      if (s1_mode_q == SOBEL) begin
         dx = dx <<< 1;
         dy = dy <<< 1;
      end
      gx = (ext[2] - ext[0]) + dx + (ext[8] - ext[6]);
      gy = (ext[0] - ext[6]) + dy + (ext[2] - ext[8]);

      s2_valid_d  = advance ? s1_valid_q  : s2_valid_q;
      gx_d        = advance ? gx          : gx_q;
      gy_d        = advance ? gy          : gy_q;
      s2_eol_d    = advance ? s1_eol_q    : s2_eol_q;
      s2_thr_on_d = advance ? s1_thr_on_q : s2_thr_on_q;
      s2_thr_d    = advance ? s1_thr_q    : s2_thr_q;
   end

   always_comb begin
      abs_x = gx_q[GW-1] ? -gx_q : gx_q;
      abs_y = gy_q[GW-1] ? -gy_q : gy_q;
      sum   = SW'(abs_x) + SW'(abs_y);
      sat   = (sum > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : sum[PIX_W-1:0];
   end

   if (THR_EN != 0) begin : g_thr
      assign result = s2_thr_on_q ? ((sat >= s2_thr_q) ? {PIX_W{1'b1}} : '0) : sat;
   end else begin : g_mag
      assign result = sat;
   end

   always_comb begin
      out_valid_d = advance ? s2_valid_q : out_valid_q;
      out_pix_d   = out_pix_q;
      out_eol_d   = out_eol_q;
      if (advance && s2_valid_q) begin
         out_pix_d = result;
         out_eol_d = s2_eol_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= '0;
         end
         s1_valid_q  <= 1'b0;
         s1_eol_q    <= 1'b0;
         s1_mode_q   <= SOBEL;
         s1_thr_on_q <= 1'b0;
         s1_thr_q    <= '0;
         s2_valid_q  <= 1'b0;
         gx_q        <= '0;
         gy_q        <= '0;
         s2_eol_q    <= 1'b0;
         s2_thr_on_q <= 1'b0;
         s2_thr_q    <= '0;
         out_valid_q <= 1'b0;
         out_pix_q   <= '0;
         out_eol_q   <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         win_q       <= win_d;
         s1_valid_q  <= s1_valid_d;
         s1_eol_q    <= s1_eol_d;
         s1_mode_q   <= s1_mode_d;
         s1_thr_on_q <= s1_thr_on_d;
         s1_thr_q    <= s1_thr_d;
         s2_valid_q  <= s2_valid_d;
         gx_q        <= gx_d;
         gy_q        <= gy_d;
         s2_eol_q    <= s2_eol_d;
         s2_thr_on_q <= s2_thr_on_d;
         s2_thr_q    <= s2_thr_d;
         out_valid_q <= out_valid_d;
         out_pix_q   <= out_pix_d;
         out_eol_q   <= out_eol_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pix   = out_pix_q;
   assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench: an 8-bit and a 10-bit instance (IMG_W=8) run the same stream and are
// compared against a direct arithmetic model of the 3x3 kernels.
module tb_sobel_stream;

   typedef struct packed {
      logic        eol;
      logic [11:0] pix;
   } item_t;

   logic clk = 1'b0;
   logic rst, mode, thr_on, in_valid, in_sof, out_ready;
   logic [7:0] thr, in_pix;
   logic in_ready8, in_ready10, out_valid8, out_valid10, out_eol8, out_eol10;
   logic [7:0] out_pix8;
   logic [9:0] out_pix10;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int first_ov = -1;
   int hold_err = 0;
   bit stall8 = 1'b0;
   logic [7:0] hold_pix;
   logic hold_eol;

   int fr_pix [64];
   bit fr_mode [64];
   bit fr_thr_on [64];
   int fr_thr [64];
   int fr_h;
   int acc_edge [64];

   item_t got8[$], got10[$], exp8[$], exp10[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sobel_stream #(.PIX_W(8), .IMG_W(8), .THR_EN(1)) dut8 (
      .clk(clk), .rst(rst), .mode(mode), .thr_on(thr_on), .thr(thr),
      .in_valid(in_valid), .in_ready(in_ready8), .in_sof(in_sof), .in_pix(in_pix),
      .out_valid(out_valid8), .out_ready(out_ready), .out_pix(out_pix8), .out_eol(out_eol8)
   );

   sobel_stream #(.PIX_W(10), .IMG_W(8), .THR_EN(1)) dut10 (
      .clk(clk), .rst(rst), .mode(mode), .thr_on(1'b0), .thr(10'd0),
      .in_valid(in_valid), .in_ready(in_ready10), .in_sof(in_sof), .in_pix({2'b00, in_pix}),
      .out_valid(out_valid10), .out_ready(out_ready), .out_pix(out_pix10), .out_eol(out_eol10)
   );

   function automatic item_t mk_item(input bit eol, input int pix);
      item_t it;
      it.eol = eol;
      it.pix = 12'(pix);
      return it;
   endfunction

   // Monitor on the falling edge: records transfers and watches output stability under stall.
   always @(negedge clk) begin
      if (rst) begin
         stall8 = 1'b0;
      end else begin
         if (stall8 && (out_valid8 !== 1'b1 || out_pix8 !== hold_pix || out_eol8 !== hold_eol))
            hold_err++;
         stall8   = out_valid8 && !out_ready;
         hold_pix = out_pix8;
         hold_eol = out_eol8;
         if (out_valid8 && out_ready) got8.push_back(mk_item(out_eol8, int'(out_pix8)));
         if (out_valid10 && out_ready) got10.push_back(mk_item(out_eol10, int'(out_pix10)));
         if (out_valid8 && first_ov < 0) first_ov = cyc;
      end
   end

   function automatic void model_frame();
      for (int r = 2; r < fr_h; r++) begin
         for (int c = 2; c < 8; c++) begin
            int idx = r * 8 + c;
            int k = fr_mode[idx] ? 1 : 2;
            int p [9];
            int gx, gy, sum, s8, s10, o8;
            for (int j = 0; j < 9; j++) p[j] = fr_pix[(r - 2 + j / 3) * 8 + (c - 2 + j % 3)];
            gx  = (p[2] - p[0]) + k * (p[5] - p[3]) + (p[8] - p[6]);
            gy  = (p[0] - p[6]) + k * (p[1] - p[7]) + (p[2] - p[8]);
            sum = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            s8  = (sum > 255) ? 255 : sum;
            s10 = (sum > 1023) ? 1023 : sum;
            o8  = fr_thr_on[idx] ? ((s8 >= fr_thr[idx]) ? 255 : 0) : s8;
            exp8.push_back(mk_item(c == 7, o8));
            exp10.push_back(mk_item(c == 7, s10));
         end
      end
   endfunction

   function automatic void set_controls(input bit m, input bit ton, input int t);
      for (int i = 0; i < 64; i++) begin
         fr_mode[i]   = m;
         fr_thr_on[i] = ton;
         fr_thr[i]    = t;
      end
   endfunction

   function automatic void clear_queues();
      got8.delete(); got10.delete(); exp8.delete(); exp10.delete();
   endfunction

   task automatic send_pixels(input int first, input int count, input bit bp, input bit gaps);
      int i = first;
      int budget = 0;
      bit acc;
      while (i < first + count) begin
         in_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_sof    = (i == 0);
         in_pix    = 8'(fr_pix[i]);
         mode      = fr_mode[i];
         thr_on    = fr_thr_on[i];
         thr       = 8'(fr_thr[i]);
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         acc = in_valid && in_ready8;
         @(posedge clk);
         #1;
         if (acc) begin
            acc_edge[i] = cyc;
            i++;
         end
         budget++;
         if (budget > 4000) begin
            checks++;
            $display("[TB] FAIL send_timeout: accepted %0d of %0d pixels", i - first, count);
            break;
         end
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (out_valid8 !== 1'b0) $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid8); else passes++;
      checks++; if (out_pix8 !== 8'd0) $display("[TB] FAIL rst_out_pix: got %0d want 0", out_pix8); else passes++;
      checks++; if (out_eol8 !== 1'b0) $display("[TB] FAIL rst_out_eol: got %b want 0", out_eol8); else passes++;
      checks++; if (in_ready8 !== 1'b1) $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready8); else passes++;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (in_ready8 !== 1'b1) $display("[TB] FAIL post_rst_in_ready: got %b want 1", in_ready8); else passes++;
      checks++; if (in_ready10 !== 1'b1) $display("[TB] FAIL post_rst_in_ready10: got %b want 1", in_ready10); else passes++;
      checks++; if (out_valid8 !== 1'b0) $display("[TB] FAIL post_rst_out_valid: got %b want 0", out_valid8); else passes++;
   endtask

   task automatic test_flat();
      clear_queues();
      fr_h = 4;
      for (int i = 0; i < 64; i++) fr_pix[i] = 100;
      set_controls(1'b0, 1'b0, 0);
      model_frame();
      send_pixels(0, 32, 1'b0, 1'b0);
      drain();
      checks++; if (got8.size() !== exp8.size()) $display("[TB] FAIL flat_count8: got %0d want %0d", got8.size(), exp8.size()); else passes++;
      checks++; if (got10.size() !== exp10.size()) $display("[TB] FAIL flat_count10: got %0d want %0d", got10.size(), exp10.size()); else passes++;
      foreach (exp8[i]) if (i < got8.size()) begin
         checks++; if (got8[i] !== exp8[i]) $display("[TB] FAIL flat8[%0d]: got pix=%0d eol=%b want pix=%0d eol=%b", i, got8[i].pix, got8[i].eol, exp8[i].pix, exp8[i].eol); else passes++;
      end
      foreach (exp10[i]) if (i < got10.size()) begin
         checks++; if (got10[i] !== exp10[i]) $display("[TB] FAIL flat10[%0d]: got pix=%0d eol=%b want pix=%0d eol=%b", i, got10[i].pix, got10[i].eol, exp10[i].pix, exp10[i].eol); else passes++;
      end
   endtask

   task automatic test_step(input bit m);
      string nm = m ? "step_prewitt" : "step_sobel";
      int want10 = m ? 765 : 1020;
      clear_queues();
      fr_h = 4;
      for (int i = 0; i < 64; i++) fr_pix[i] = ((i % 8) < 4) ? 0 : 255;
      set_controls(m, 1'b0, 0);
      model_frame();
      send_pixels(0, 32, 1'b0, 1'b0);
      drain();
      checks++; if (got8.size() !== exp8.size()) $display("[TB] FAIL %s_count8: got %0d want %0d", nm, got8.size(), exp8.size()); else passes++;
      checks++; if (got10.size() !== exp10.size()) $display("[TB] FAIL %s_count10: got %0d want %0d", nm, got10.size(), exp10.size()); else passes++;
      foreach (exp8[i]) if (i < got8.size()) begin
         checks++; if (got8[i] !== exp8[i]) $display("[TB] FAIL %s8[%0d]: got pix=%0d eol=%b want pix=%0d eol=%b", nm, i, got8[i].pix, got8[i].eol, exp8[i].pix, exp8[i].eol); else passes++;
      end
      foreach (exp10[i]) if (i < got10.size()) begin
         checks++; if (got10[i] !== exp10[i]) $display("[TB] FAIL %s10[%0d]: got pix=%0d eol=%b want pix=%0d eol=%b", nm, i, got10[i].pix, got10[i].eol, exp10[i].pix, exp10[i].eol); else passes++;
      end
      checks++; if (got8.size() < 4 || got8[2].pix !== 12'd255 || got8[3].pix !== 12'd255) $display("[TB] FAIL %s_edge8: got %0d want 255", nm, (got8.size() < 4) ? -1 : int'(got8[2].pix)); else passes++;
      checks++; if (got10.size() < 4 || int'(got10[2].pix) != want10) $display("[TB] FAIL %s_edge10: got %0d want %0d", nm, (got10.size() < 4) ? -1 : int'(got10[2].pix), want10); else passes++;
   endtask

   task automatic test_threshold();
      clear_queues();
      fr_h = 3;
      for (int i = 0; i < 64; i++) fr_pix[i] = 8 * (i % 8);
      set_controls(1'b0, 1'b1, 128);
      model_frame();
      send_pixels(0, 24, 1'b0, 1'b0);
      set_controls(1'b0, 1'b1, 64);
      model_frame();
      send_pixels(0, 24, 1'b0, 1'b0);
      drain();
      checks++; if (got8.size() !== exp8.size()) $display("[TB] FAIL thr_count8: got %0d want %0d", got8.size(), exp8.size()); else passes++;
      foreach (exp8[i]) if (i < got8.size()) begin
         checks++; if (got8[i] !== exp8[i]) $display("[TB] FAIL thr8[%0d]: got pix=%0d eol=%b want pix=%0d eol=%b", i, got8[i].pix, got8[i].eol, exp8[i].pix, exp8[i].eol); else passes++;
      end
      checks++; if (got10.size() < 1 || got10[0].pix !== 12'd64) $display("[TB] FAIL thr_mag10: got %0d want 64", (got10.size() < 1) ? -1 : int'(got10[0].pix)); else passes++;
   endtask

   task automatic test_sof_restart();
      clear_queues();
      fr_h = 4;
      for (int i = 0; i < 64; i++) fr_pix[i] = $urandom_range(0, 255);
      set_controls(1'b1, 1'b0, 0);
      send_pixels(0, 11, 1'b0, 1'b0);
      model_frame();
      send_pixels(0, 32, 1'b0, 1'b0);
      drain();
      checks++; if (got8.size() !== exp8.size()) $display("[TB] FAIL sof_count8: got %0d want %0d", got8.size(), exp8.size()); else passes++;
      foreach (exp8[i]) if (i < got8.size()) begin
         checks++; if (got8[i] !== exp8[i]) $display("[TB] FAIL sof8[%0d]: got pix=%0d eol=%b want pix=%0d eol=%b", i, got8[i].pix, got8[i].eol, exp8[i].pix, exp8[i].eol); else passes++;
      end
   endtask

   task automatic test_backpressure();
      clear_queues();
      hold_err = 0;
      fr_h = 8;
      for (int i = 0; i < 64; i++) begin
         fr_pix[i]    = $urandom_range(0, 255);
         fr_mode[i]   = 1'($urandom_range(0, 1));
         fr_thr_on[i] = 1'($urandom_range(0, 1));
         fr_thr[i]    = $urandom_range(0, 255);
      end
      model_frame();
      send_pixels(0, 64, 1'b1, 1'b1);
      drain();
      checks++; if (got8.size() !== 36) $display("[TB] FAIL bp_count8: got %0d want 36", got8.size()); else passes++;
      checks++; if (got10.size() !== exp10.size()) $display("[TB] FAIL bp_count10: got %0d want %0d", got10.size(), exp10.size()); else passes++;
      checks++; if (hold_err !== 0) $display("[TB] FAIL bp_hold: got %0d unstable stalled cycles want 0", hold_err); else passes++;
      foreach (exp8[i]) if (i < got8.size()) begin
         checks++; if (got8[i] !== exp8[i]) $display("[TB] FAIL bp8[%0d]: got pix=%0d eol=%b want pix=%0d eol=%b", i, got8[i].pix, got8[i].eol, exp8[i].pix, exp8[i].eol); else passes++;
      end
      foreach (exp10[i]) if (i < got10.size()) begin
         checks++; if (got10[i] !== exp10[i]) $display("[TB] FAIL bp10[%0d]: got pix=%0d eol=%b want pix=%0d eol=%b", i, got10[i].pix, got10[i].eol, exp10[i].pix, exp10[i].eol); else passes++;
      end
   endtask

   task automatic test_reset_midframe();
      fr_h = 5;
      for (int i = 0; i < 64; i++) fr_pix[i] = $urandom_range(0, 255);
      set_controls(1'b0, 1'b0, 0);
      send_pixels(0, 36, 1'b0, 1'b0);
      rst = 1'b1;
      #2;
      checks++; if (out_valid8 !== 1'b0) $display("[TB] FAIL mid_rst_valid: got %b want 0", out_valid8); else passes++;
      checks++; if (out_pix8 !== 8'd0) $display("[TB] FAIL mid_rst_pix: got %0d want 0", out_pix8); else passes++;
      checks++; if (in_ready8 !== 1'b1) $display("[TB] FAIL mid_rst_in_ready: got %b want 1", in_ready8); else passes++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_queues();
      first_ov = -1;
      fr_h = 3;
      for (int i = 0; i < 64; i++) fr_pix[i] = $urandom_range(0, 255);
      model_frame();
      send_pixels(0, 24, 1'b0, 1'b0);
      drain();
      checks++; if (first_ov != acc_edge[18] + 2) $display("[TB] FAIL latency: first out_valid after edge %0d want %0d", first_ov, acc_edge[18] + 2); else passes++;
      checks++; if (got8.size() !== exp8.size()) $display("[TB] FAIL mid_count8: got %0d want %0d", got8.size(), exp8.size()); else passes++;
      foreach (exp8[i]) if (i < got8.size()) begin
         checks++; if (got8[i] !== exp8[i]) $display("[TB] FAIL mid8[%0d]: got pix=%0d eol=%b want pix=%0d eol=%b", i, got8[i].pix, got8[i].eol, exp8[i].pix, exp8[i].eol); else passes++;
      end
   endtask

   initial begin
      rst       = 1'b1;
      mode      = 1'b0;
      thr_on    = 1'b0;
      thr       = 8'd0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_pix    = 8'd0;
      out_ready = 1'b1;
      test_reset();
      test_flat();
      test_step(1'b0);
      test_step(1'b1);
      test_threshold();
      test_sof_restart();
      test_backpressure();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
